// File: rtl/ddr4_dimm_responder.sv
// rtl/ddr4_dimm_responder.sv - DDR4 DIMM responder: per-bank state, word storage, CAS read pipeline
// Optional error reporting is enabled by defining DDR4_DIMM_PROTOCOL_CHECK_EN.
module ddr4_dimm_responder #(
    parameter int CAS_LATENCY        = 22,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int BANK_GROUPS        = 4,
    parameter int BANKS_PER_GROUP    = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               cs_N_in,
    input  logic                               act_in,
    input  logic [16:0]                        dram_addr_in,
    input  logic [$clog2(BANK_GROUPS)-1:0]     bg_in,
    input  logic [$clog2(BANKS_PER_GROUP)-1:0] ba_in,
    input  logic [63:0]                        dqm_in,
    inout  wire  [63:0]                        dqs,
    output logic                               rd_valid_out,
    output logic                               protocol_err_out,
    output logic [15:0]                        err_count_out
);

    localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int ADDR_W    = BANK_W + ROW_BITS + COL_BITS;
    localparam int MAX_LAT   = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_ACTIVATING  = 2'd1;
    localparam logic [1:0] ST_ACTIVE      = 2'd2;
    localparam logic [1:0] ST_PRECHARGING = 2'd3;

    logic [1:0]          bank_state [NUM_BANKS];
    logic [ROW_BITS-1:0] bank_row   [NUM_BANKS];
    logic [CNT_W-1:0]    bank_cnt   [NUM_BANKS];
    logic [63:0]         mem        [1 << ADDR_W];

    logic [CAS_LATENCY-1:0] pipe_valid;
    logic [63:0]            pipe_data [CAS_LATENCY];

    logic [BANK_W-1:0]   bank_idx;
    logic [2:0]          cmd_code;
    logic                cmd_en;
    logic                is_act, is_rd, is_wr, is_pre;
    logic                do_act, do_rd, do_wr, do_pre;
    logic                illegal;
    logic [1:0]          cur_state;
    logic [ROW_BITS-1:0] cur_row;
    logic [ADDR_W-1:0]   mem_addr;
    logic                unused_addr;

    assign bank_idx  = BANK_W'(bg_in) * BANK_W'(BANKS_PER_GROUP) + BANK_W'(ba_in);
    assign cmd_code  = dram_addr_in[16:14];
    assign cmd_en    = !cs_N_in && !rst_in;
    assign is_act    = cmd_en && !act_in;
    assign is_rd     = cmd_en && act_in && (cmd_code == 3'b101);
    assign is_wr     = cmd_en && act_in && (cmd_code == 3'b100);
    assign is_pre    = cmd_en && act_in && (cmd_code == 3'b010);
    assign cur_state = bank_state[bank_idx];
    assign cur_row   = bank_row[bank_idx];
    assign mem_addr  = {bank_idx, cur_row, dram_addr_in[COL_BITS-1:0]};
    assign unused_addr = ^dram_addr_in[13:ROW_BITS];

    // Busy banks accept nothing; every legal command needs a settled bank state.
    assign do_act  = is_act && (cur_state == ST_IDLE);
    assign do_rd   = is_rd  && (cur_state == ST_ACTIVE);
    assign do_wr   = is_wr  && (cur_state == ST_ACTIVE);
    assign do_pre  = is_pre && (cur_state == ST_ACTIVE);
    assign illegal = (is_act || is_rd || is_wr || is_pre) && !(do_act || do_rd || do_wr || do_pre);

    // Counter is loaded with latency-1 so the bank is usable exactly LATENCY cycles after the command.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rst_in) begin
                bank_state[i] <= ST_IDLE;
                bank_cnt[i]   <= '0;
            end else if (do_act && (bank_idx == BANK_W'(i))) begin
                bank_state[i] <= (ACTIVATION_LATENCY <= 1) ? ST_ACTIVE : ST_ACTIVATING;
                bank_row[i]   <= dram_addr_in[ROW_BITS-1:0];
                bank_cnt[i]   <= CNT_W'(ACTIVATION_LATENCY - 1);
            end else if (do_pre && (bank_idx == BANK_W'(i))) begin
                bank_state[i] <= (PRECHARGE_LATENCY <= 1) ? ST_IDLE : ST_PRECHARGING;
                bank_cnt[i]   <= CNT_W'(PRECHARGE_LATENCY - 1);
            end else if (bank_state[i] == ST_ACTIVATING || bank_state[i] == ST_PRECHARGING) begin
                if (bank_cnt[i] <= CNT_W'(1)) begin
                    bank_state[i] <= (bank_state[i] == ST_ACTIVATING) ? ST_ACTIVE : ST_IDLE;
                end else begin
                    bank_cnt[i] <= bank_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_wr) begin
            mem[mem_addr] <= (mem[mem_addr] & dqm_in) | (dqs & ~dqm_in);
        end
    end

    // Data is captured at command time, so later writes cannot disturb an in-flight read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= do_rd;
            for (int s = 1; s < CAS_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        pipe_data[0] <= mem[mem_addr];
        for (int s = 1; s < CAS_LATENCY; s++) begin
            pipe_data[s] <= pipe_data[s-1];
        end
    end

    assign rd_valid_out = pipe_valid[CAS_LATENCY-1];
    assign dqs          = rd_valid_out ? pipe_data[CAS_LATENCY-1] : {64{1'bz}};

`ifdef DDR4_DIMM_PROTOCOL_CHECK_EN
    logic        err_flag;
    logic [15:0] err_count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else if (illegal) begin
            err_flag <= 1'b1;
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            $display("ddr4_dimm_responder: dropped illegal command, bank %0d state %0d", bank_idx, cur_state);
        end
    end

    assign protocol_err_out = err_flag;
    assign err_count_out    = err_count;
`else
    logic unused_illegal;
    assign unused_illegal   = illegal;
    assign protocol_err_out = 1'b0;
    assign err_count_out    = 16'h0000;
`endif

endmodule
